// File: rtl/pcpu_run_ctrl_pkg.sv
// Shared definitions for the pipelined-CPU run controller: state encoding,
// HALT opcode, drain length and the step-length helper.
package pcpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StRun    = 3'd1,
    StStep   = 3'd2,
    StPaused = 3'd3,
    StDrain  = 3'd4,
    StHalted = 3'd5
  } run_state_e;

  localparam logic [4:0] HALT_OP      = 5'b00001;
  localparam logic [3:0] DRAIN_CYCLES = 4'd4;

  // A step length of zero is treated as a single cycle.
  function automatic logic [3:0] step_len(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/pcpu_run_ctrl_cnt.sv
// Loadable 4-bit down-counter shared by the STEP and DRAIN phases.
module run_ctrl_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       is_one
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one = (cnt_q == 4'd1);

endmodule

// File: rtl/pcpu_run_ctrl.sv
// Run/step/stop controller for a pipelined CPU with HALT drain and an optional
// instruction-address breakpoint enabled by defining RUN_CTRL_BP_EN.
module pcpu_run_ctrl
  import pcpu_run_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        btn_step,
  input  logic        btn_stop,
  input  logic [3:0]  step_n,
  input  logic [7:0]  bp_addr,
  input  logic        bp_valid,
  input  logic [7:0]  i_addr,
  input  logic [15:0] i_datain,
  output logic        cpu_enable,
  output logic        cpu_start,
  output logic [2:0]  run_state,
  output logic [15:0] cycle_count,
  output logic        bp_hit
);

  run_state_e  state_q, state_d;
  logic        cpu_enable_q, cpu_enable_d;
  logic        cpu_start_q, cpu_start_d;
  logic [15:0] cycle_count_q;
  logic        cnt_load, cnt_dec, cnt_is_one;
  logic [3:0]  cnt_load_val;
  logic        halt_det, bp_match, bp_pause;

  assign halt_det = cpu_enable_q && (i_datain[15:11] == HALT_OP);

`ifdef RUN_CTRL_BP_EN
  assign bp_match = bp_valid && (i_addr == bp_addr);
`else
  assign bp_match = 1'b0;
`endif

  run_ctrl_cnt u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  // Within RUN/STEP: stop > halt > breakpoint > step expiry.
  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = 4'd0;
    cnt_dec      = 1'b0;
    bp_pause     = 1'b0;
    unique case (state_q)
      StIdle, StPaused: begin
        if (btn_start) begin
          state_d = StRun;
        end else if (btn_step) begin
          state_d      = StStep;
          cnt_load     = 1'b1;
          cnt_load_val = step_len(step_n);
        end
      end
      StRun, StStep: begin
        if (btn_stop) begin
          state_d = StPaused;
        end else if (halt_det) begin
          state_d      = StDrain;
          cnt_load     = 1'b1;
          cnt_load_val = DRAIN_CYCLES;
        end else if (bp_match) begin
          state_d  = StPaused;
          bp_pause = 1'b1;
        end else if (state_q == StStep) begin
          cnt_dec = 1'b1;
          if (cnt_is_one) begin
            state_d = StPaused;
          end
        end
      end
      StDrain: begin
        cnt_dec = 1'b1;
        if (cnt_is_one) begin
          state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    cpu_enable_d = (state_d == StRun) || (state_d == StStep) || (state_d == StDrain);
    cpu_start_d  = ((state_q == StIdle) || (state_q == StPaused)) &&
                   ((state_d == StRun) || (state_d == StStep));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cpu_enable_q  <= 1'b0;
      cpu_start_q   <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cpu_enable_q <= cpu_enable_d;
      cpu_start_q  <= cpu_start_d;
      if (cpu_enable_q && (cycle_count_q != 16'hFFFF)) begin
        cycle_count_q <= cycle_count_q + 16'd1;
      end
    end
  end

`ifdef RUN_CTRL_BP_EN
  logic bp_hit_q, bp_hit_d;

  always_comb begin
    bp_hit_d = bp_hit_q;
    if ((state_q == StPaused) && (state_d != StPaused)) begin
      bp_hit_d = 1'b0;
    end
    if (bp_pause) begin
      bp_hit_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  assign bp_hit = bp_hit_q;

  logic unused_in;
  assign unused_in = ^i_datain[10:0];
`else
  assign bp_hit = 1'b0;

  // Breakpoint inputs have no function in this build.
  logic unused_in;
  assign unused_in = ^{bp_addr, bp_valid, i_addr, i_datain[10:0], bp_pause};
`endif

  assign cpu_enable  = cpu_enable_q;
  assign cpu_start   = cpu_start_q;
  assign run_state   = state_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_pcpu_run_ctrl.sv
// Directed self-checking bench for pcpu_run_ctrl; breakpoint expectations
// follow whether RUN_CTRL_BP_EN is defined.
module tb_pcpu_run_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_start = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_stop = 1'b0;
  logic [3:0]  step_n = 4'd0;
  logic [7:0]  bp_addr = 8'd0;
  logic        bp_valid = 1'b0;
  logic [7:0]  i_addr = 8'd0;
  logic [15:0] i_datain = 16'd0;
  logic        cpu_enable;
  logic        cpu_start;
  logic [2:0]  run_state;
  logic [15:0] cycle_count;
  logic        bp_hit;

  int n_total = 0;
  int n_bad = 0;

  pcpu_run_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_step    (btn_step),
    .btn_stop    (btn_stop),
    .step_n      (step_n),
    .bp_addr     (bp_addr),
    .bp_valid    (bp_valid),
    .i_addr      (i_addr),
    .i_datain    (i_datain),
    .cpu_enable  (cpu_enable),
    .cpu_start   (cpu_start),
    .run_state   (run_state),
    .cycle_count (cycle_count),
    .bp_hit      (bp_hit)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    btn_start = 1'b0;
    btn_step  = 1'b0;
    btn_stop  = 1'b0;
    i_datain  = 16'd0;
    bp_valid  = 1'b0;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    btn_start = 1'b1;
    tick();
    btn_start = 1'b0;
  endtask

  initial begin
    int n_en;
    int n_drain;

    // Reset state
    tick();
    check_eq("rst_state", run_state, 0);
    check_eq("rst_en", cpu_enable, 0);
    check_eq("rst_start", cpu_start, 0);
    check_eq("rst_count", cycle_count, 0);
    check_eq("rst_bp", bp_hit, 0);
    reset = 1'b0;

    // Start at cycle 2, cpu_start only in cycle 3
    tick();                        // cycle 1
    check_eq("c1_start", cpu_start, 0);
    pulse_start();                 // button during cycle 2
    check_eq("c3_start", cpu_start, 1);
    check_eq("c3_en", cpu_enable, 1);
    check_eq("c3_state", run_state, 1);
    tick();
    check_eq("c4_start", cpu_start, 0);
    check_eq("c4_en", cpu_enable, 1);
    btn_stop = 1'b1;
    tick();
    btn_stop = 1'b0;
    check_eq("stop_state", run_state, 3);
    check_eq("stop_en", cpu_enable, 0);
    check_eq("stop_count", cycle_count, 2);

    // Step of 3, then step_n=0 acting as 1
    do_reset();
    step_n   = 4'd3;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    check_eq("step_state", run_state, 2);
    check_eq("step_start", cpu_start, 1);
    n_en = 0;
    for (int i = 0; i < 8; i++) begin
      if (cpu_enable) n_en++;
      tick();
    end
    check_eq("step3_cycles", n_en, 3);
    check_eq("step3_count", cycle_count, 3);
    check_eq("step3_state", run_state, 3);
    step_n   = 4'd0;
    btn_step = 1'b1;
    tick();
    btn_step = 1'b0;
    n_en = 0;
    for (int i = 0; i < 6; i++) begin
      if (cpu_enable) n_en++;
      tick();
    end
    check_eq("step0_cycles", n_en, 1);
    check_eq("step0_count", cycle_count, 4);
    check_eq("step0_state", run_state, 3);

    // HALT -> DRAIN x4 -> HALTED, start then ignored
    do_reset();
    pulse_start();
    i_datain = 16'h0800;
    tick();
    i_datain = 16'h0000;
    check_eq("drain_state", run_state, 4);
    n_drain = 0;
    for (int i = 0; i < 10; i++) begin
      if (run_state == 3'd4) begin
        check_eq("drain_en", cpu_enable, 1);
        n_drain++;
        tick();
      end
    end
    check_eq("drain_cycles", n_drain, 4);
    check_eq("halted_state", run_state, 5);
    check_eq("halted_en", cpu_enable, 0);
    check_eq("halted_count", cycle_count, 5);
    pulse_start();
    tick();
    check_eq("halted_start_state", run_state, 5);
    check_eq("halted_start_en", cpu_enable, 0);
    check_eq("halted_start_pulse", cpu_start, 0);

    // Reset asserted mid-DRAIN takes effect without a clock edge
    do_reset();
    pulse_start();
    i_datain = 16'h0800;
    tick();
    i_datain = 16'h0000;
    tick();
    check_eq("mid_drain_state", run_state, 4);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_state", run_state, 0);
    check_eq("async_en", cpu_enable, 0);
    check_eq("async_start", cpu_start, 0);
    check_eq("async_count", cycle_count, 0);
    check_eq("async_bp", bp_hit, 0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    check_eq("post_rst_state", run_state, 0);
    check_eq("post_rst_en", cpu_enable, 0);

    // btn_stop and HALT in the same cycle -> PAUSED
    do_reset();
    pulse_start();
    btn_stop = 1'b1;
    i_datain = 16'h0800;
    tick();
    btn_stop = 1'b0;
    i_datain = 16'h0000;
    check_eq("stop_halt_state", run_state, 3);
    check_eq("stop_halt_en", cpu_enable, 0);

    // Breakpoint at 0x10
    do_reset();
    bp_addr  = 8'h10;
    bp_valid = 1'b1;
    i_addr   = 8'h0E;
    pulse_start();
    i_addr = 8'h0F;
    tick();
    check_eq("bp_pre_state", run_state, 1);
    i_addr = 8'h10;
    tick();
`ifdef RUN_CTRL_BP_EN
    check_eq("bp_state", run_state, 3);
    check_eq("bp_en", cpu_enable, 0);
    check_eq("bp_flag", bp_hit, 1);
    i_addr = 8'h11;
    pulse_start();
    check_eq("bp_resume_state", run_state, 1);
    check_eq("bp_resume_flag", bp_hit, 0);
`else
    check_eq("nobp_state", run_state, 1);
    check_eq("nobp_en", cpu_enable, 1);
    check_eq("nobp_flag", bp_hit, 0);
`endif
    bp_valid = 1'b0;

    // Long run: cycle_count saturates
    do_reset();
    pulse_start();
    repeat (65534) @(posedge clock);
    #1;
    check_eq("sat_pre", cycle_count, 16'hFFFE);
    tick();
    check_eq("sat_hit", cycle_count, 16'hFFFF);
    tick();
    tick();
    tick();
    check_eq("sat_hold", cycle_count, 16'hFFFF);
    check_eq("sat_state", run_state, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pcpu_run_ctrl.md
PCPU_RUN_CTRL -- requirements
Module: pcpu_run_ctrl

Interface
REQ-001 SHALL have port clock, input, 1, single system clock; all logic on its rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port btn_start, input, 1, one-cycle pulse (already debounced), requests continuous run.
REQ-004 SHALL have port btn_step, input, 1, one-cycle pulse, requests a bounded run of step_n cycles.
REQ-005 SHALL have port btn_stop, input, 1, one-cycle pulse, requests a pause.
REQ-006 SHALL have port step_n, input, 4, step length in CPU cycles; 0 means 1.
REQ-007 SHALL have port bp_addr, input, 8, breakpoint instruction address.
REQ-008 SHALL have port bp_valid, input, 1, breakpoint armed.
REQ-009 SHALL have port i_addr, input, 8, CPU fetch address (monitored).
REQ-010 SHALL have port i_datain, input, 16, instruction word returned to the CPU (monitored).
REQ-011 SHALL have port cpu_enable, output, 1, registered; drives CPU enable.
REQ-012 SHALL have port cpu_start, output, 1, registered one-cycle pulse; drives CPU start.
REQ-013 SHALL have port run_state, output, 3, current FSM state encoding.
REQ-014 SHALL have port cycle_count, output, 16, number of enabled CPU cycles since reset.
REQ-015 SHALL have port bp_hit, output, 1, sticky flag: last pause was caused by the breakpoint.

Function
REQ-016 SHALL implement states IDLE=0, RUN=1, STEP=2, PAUSED=3, DRAIN=4, HALTED=5.
REQ-017 SHALL transition IDLE/PAUSED + btn_start to RUN; next cycle cpu_enable=1 and cpu_start=1 for exactly one cycle.
REQ-018 SHALL transition IDLE/PAUSED + btn_step to STEP and load step counter with max(step_n,1); cpu_enable and cpu_start timing as in REQ-017.
REQ-019 SHALL decrement the step counter each STEP cycle; when it equals 1, SHALL go to PAUSED with cpu_enable=0 on the following cycle (exactly step_n enabled cycles).
REQ-020 SHALL transition RUN/STEP + btn_stop to PAUSED, with cpu_enable=0 on the next cycle.
REQ-021 SHALL give priority, within a cycle: btn_stop > halt detect > breakpoint > step expiry > btn_start > btn_step.
REQ-022 SHALL detect HALT when cpu_enable=1 and i_datain[15:11]==HALT_OP, then enter DRAIN.
REQ-023 SHALL keep cpu_enable=1 in DRAIN for DRAIN_CYCLES=4 cycles so HALT reaches write-back, then enter HALTED with cpu_enable=0.
REQ-024 SHALL ignore btn_stop and btn_step in DRAIN; HALTED SHALL be left only by reset.
REQ-025 SHALL ignore btn_start in RUN/STEP and all buttons other than those listed in IDLE/PAUSED.
REQ-026 SHALL increment cycle_count on every cycle in which cpu_enable=1, saturating at 16'hFFFF.
REQ-027 SHALL clear bp_hit on any transition out of PAUSED, and set it on a breakpoint pause.

Reset
REQ-028 SHALL on reset asynchronously force state IDLE, cpu_enable=0, cpu_start=0, cycle_count=0, bp_hit=0, step counter=0, drain counter=0.
REQ-029 SHALL, when reset is asserted mid-RUN/STEP/DRAIN, discard all pending requests; no pulse is replayed after reset release.

Configuration
REQ-030 SHALL support macro RUN_CTRL_BP_EN: when defined, RUN/STEP with bp_valid=1 and i_addr==bp_addr go to PAUSED (cpu_enable=0 next cycle) and set bp_hit; when undefined, bp_addr/bp_valid are ignored and bp_hit is tied to 0.

Structure
REQ-031 SHALL place the state encoding, HALT_OP (5'b00001) and DRAIN_CYCLES in the shared header package.
REQ-032 SHALL be a single module; the step/drain down-counter MAY be a sub-module named run_ctrl_cnt.

Verification
REQ-033 SHALL check: reset, btn_start at cycle 2 -> cpu_start high only at cycle 3, cpu_enable high from cycle 3, run_state=1.
REQ-034 SHALL check: step_n=3, btn_step -> exactly 3 cycles of cpu_enable=1, cycle_count=3, run_state=3; step_n=0 -> exactly 1 cycle.
REQ-035 SHALL check: RUN, i_datain=16'h0800 (HALT) -> DRAIN for 4 cycles, then HALTED, cpu_enable=0; btn_start afterwards has no effect.
REQ-036 SHALL check (RUN_CTRL_BP_EN): bp_addr=8'h10, bp_valid=1, i_addr reaches 8'h10 -> cpu_enable=0 next cycle, bp_hit=1; without the macro the run continues.
REQ-037 SHALL check: btn_stop and HALT in the same cycle -> PAUSED, not DRAIN; cycle_count saturates at 16'hFFFF after forced long run.
REQ-038 SHALL check: reset asserted mid-DRAIN -> all outputs 0 and IDLE immediately, without waiting for a clock edge.
